spi_slave_param: RTL and testbench
==================================

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word length in bits (range 4..32).
REQ-002 SHALL have parameter CPOL, default 0, SCK idle level.
REQ-003 SHALL have parameter CPHA, default 0. 0 samples on the leading edge; 1 samples on the trailing edge.
REQ-004 SHALL have parameter MSB_FIRST, default 1. Bit order for both RX and TX.
REQ-005 SHALL have parameter IDLE_FILL, default all ones, DATA_W wide. Word shifted out on TX underrun.
REQ-006 clk  in  1  system clock; frequency at least 4x SCK.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 SSEL  in  1  chip select, active-low, asynchronous to clk.
REQ-009 SCK  in  1  SPI clock, asynchronous to clk.
REQ-010 MOSI  in  1  master data in.
REQ-011 MISO  out  1  slave data out.
REQ-012 MISO_oe  out  1  MISO output enable; high while a frame is active.
REQ-013 tx_data  in  DATA_W  next word to transmit.
REQ-014 tx_valid  in  1  tx_data valid.
REQ-015 tx_ready  out  1  one-entry TX holding register is empty.
REQ-016 rx_data  out  DATA_W  last complete received word.
REQ-017 rx_valid  out  1  one-cycle pulse when rx_data is updated.
REQ-018 underrun  out  1  one-cycle pulse when IDLE_FILL is loaded instead of user data.
REQ-019 abort  out  1  one-cycle pulse when SSEL deasserts mid-word.
REQ-020 frame_active  out  1  FSM in ACTIVE.

Function
REQ-021 SCK, SSEL and MOSI SHALL pass through 2-flop synchronizers; edges SHALL be detected on the synchronized SCK/SSEL with a third register stage.
REQ-022 Leading edge SHALL be rising when CPOL=0 and falling when CPOL=1.
REQ-023 The sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; the shift edge is the other one.
REQ-024 FSM states SHALL be WAIT_IDLE, IDLE and ACTIVE:
- WAIT_IDLE goes to IDLE when synchronized SSEL is high.
- IDLE goes to ACTIVE on the synchronized SSEL falling edge.
- ACTIVE goes to IDLE on the synchronized SSEL rising edge.
REQ-025 A bit counter 0..DATA_W-1 SHALL advance on each sample edge in ACTIVE and wrap to 0 after DATA_W-1; words run back-to-back within one SSEL-low period.
REQ-026 On the sample edge with count DATA_W-1, rx_data SHALL be updated and rx_valid SHALL pulse in the next clk cycle. There is no backpressure, so an unread word is overwritten.
REQ-027 Word load, CPHA=0: SHALL occur on entry to ACTIVE and on the shift edge following the final sample of each word.
REQ-028 Word load, CPHA=1: SHALL occur on the first shift edge of each word (count 0); the first bit is driven on that edge.
REQ-029 On word load, a full holding register SHALL go to the shift register and be emptied (tx_ready rises next cycle). If the holding register is empty, IDLE_FILL is loaded and underrun pulses.
REQ-030 The holding register SHALL accept tx_data when tx_valid and tx_ready are both high. tx_ready is registered.
REQ-031 If a write coincides with a load from an empty holding register, the load SHALL use IDLE_FILL with underrun, and the written word SHALL stay for the next word.
REQ-032 MISO SHALL present the MSB (MSB_FIRST=1) or LSB of the shift register. Non-load shift edges advance one bit; RX shifts in the same direction.
REQ-033 MISO SHALL be 0 and MISO_oe 0 outside ACTIVE.
REQ-034 SSEL rising with count not 0 SHALL discard the partial word, pulse abort, and produce no rx_valid; a consumed TX word is not restored.
REQ-035 SCK edges outside ACTIVE SHALL be ignored.

Reset
REQ-036 On reset the block SHALL set MISO=0, MISO_oe=0, tx_ready=1, rx_data=0, rx_valid=0, underrun=0, abort=0 and frame_active=0, clear bit count and registers, and enter WAIT_IDLE.
REQ-037 If reset releases with SSEL low, the block SHALL ignore that frame until SSEL has been high.

Structure
REQ-038 Shared package spi_pkg SHALL hold the FSM state encoding and the CPOL/CPHA mode constants.
REQ-039 Sub-module spi_sync_edge SHALL implement synchronizer plus rise/fall detect, instantiated for SCK and SSEL; MOSI uses its synchronizer only.

Verification
REQ-040 Mode 0, DATA_W=8, tx 8'hA5 preloaded, master sends 8'h3C MSB-first -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; exactly one rx_valid.
REQ-041 Mode 3, two back-to-back words 8'h01 then 8'h80 in one frame, only 8'hC3 written -> MISO 8'hC3 then 8'hFF; one underrun; two rx_valid pulses.
REQ-042 MSB_FIRST=0, DATA_W=16, master sends 16'h1234 LSB-first -> rx_data=16'h1234.
REQ-043 SSEL high after 5 bits -> abort pulse, no rx_valid; next frame 8'h55 received correctly.
REQ-044 Reset asserted at bit 3, released with SSEL low -> outputs at reset values, no rx_valid until SSEL cycles high then low; then 8'h96 received correctly.
REQ-045 tx_valid in the same cycle as a load from an empty holding register -> underrun and IDLE_FILL sent; the written word is sent in the following word.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the parameterised SPI slave: FSM encoding and SPI mode constants.
package spi_pkg;

  typedef enum logic [1:0] {
    StWaitIdle,
    StIdle,
    StActive
  } spi_state_e;

  localparam bit CPOL_IDLE_LOW  = 1'b0;
  localparam bit CPOL_IDLE_HIGH = 1'b1;
  localparam bit CPHA_LEADING   = 1'b0;
  localparam bit CPHA_TRAILING  = 1'b1;

  localparam logic [1:0] SPI_MODE0 = 2'd0;
  localparam logic [1:0] SPI_MODE1 = 2'd1;
  localparam logic [1:0] SPI_MODE2 = 2'd2;
  localparam logic [1:0] SPI_MODE3 = 2'd3;

  function automatic logic [1:0] spi_mode(input bit cpol, input bit cpha);
    return {cpol, cpha};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with a third stage for rise/fall detection.
module spi_sync_edge #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [2:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= {3{RST_VAL}};
    end else begin
      sr_q <= {sr_q[1:0], din};
    end
  end

  assign sync = sr_q[1];
  assign rise = sr_q[1] & ~sr_q[2];
  assign fall = ~sr_q[1] & sr_q[2];

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave with configurable word length, mode and bit order; oversampled by the system clock.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int unsigned        DATA_W    = 8,
  parameter bit                 CPOL      = 1'b0,
  parameter bit                 CPHA      = 1'b0,
  parameter bit                 MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0]  IDLE_FILL = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SSEL,
  input  logic              SCK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              abort,
  output logic              frame_active
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  logic sck_s, sck_rise, sck_fall;
  logic ssel_s, ssel_rise, ssel_fall;
  logic [1:0] mosi_q;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sck (
    .clk  (clk),
    .rst  (rst),
    .din  (SCK),
    .sync (sck_s),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // Synchronized SSEL resets low so a frame in progress at reset release is not mistaken for idle.
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_ssel (
    .clk  (clk),
    .rst  (rst),
    .din  (SSEL),
    .sync (ssel_s),
    .rise (ssel_rise),
    .fall (ssel_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  // Leading edge moves SCK away from its idle level.
  logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  assign sck_edge    = sck_rise | sck_fall;
  assign lead_edge   = sck_edge & (sck_s != CPOL);
  assign trail_edge  = sck_edge & (sck_s == CPOL);
  assign sample_edge = (CPHA == CPHA_LEADING) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == CPHA_LEADING) ? trail_edge : lead_edge;

  spi_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitIdle: if (ssel_s)    state_d = StIdle;
      StIdle:     if (ssel_fall) state_d = StActive;
      StActive:   if (ssel_rise) state_d = StIdle;
      default:                   state_d = StWaitIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StWaitIdle;
    end else begin
      state_q <= state_d;
    end
  end

  logic              active, entry, sample_act, shift_act, load, write, cnt_last;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] shift_q, rx_shift_q, rx_data_q, hold_q;
  logic [DATA_W-1:0] shift_next, rx_next;
  logic              hold_full_q, rx_valid_q, underrun_q, abort_q;

  assign active     = (state_q == StActive);
  assign entry      = (state_q == StIdle) & ssel_fall;
  assign sample_act = active & sample_edge;
  assign shift_act  = active & shift_edge;
  assign cnt_last   = (cnt_q == CntLast);
  // CPHA=0 must have the first bit on MISO before the first edge, so it loads on frame entry too.
  assign load       = ((CPHA == CPHA_LEADING) & entry) | (shift_act & (cnt_q == '0));
  assign write      = tx_valid & ~hold_full_q;

  assign shift_next = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0} : {1'b0, shift_q[DATA_W-1:1]};
  assign rx_next    = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi_q[1]}
                                : {mosi_q[1], rx_shift_q[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
      if (write) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end
      // A write can only happen while the holding register is empty, so it never races a full load.
      if (load) begin
        if (hold_full_q) begin
          shift_q     <= hold_q;
          hold_full_q <= 1'b0;
        end else begin
          shift_q    <= IDLE_FILL;
          underrun_q <= 1'b1;
        end
      end else if (shift_act) begin
        shift_q <= shift_next;
      end
      if (sample_act) begin
        rx_shift_q <= rx_next;
        if (cnt_last) begin
          cnt_q      <= '0;
          rx_data_q  <= rx_next;
          rx_valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (active && ssel_rise) begin
        cnt_q <= '0;
        if (cnt_q != '0) abort_q <= 1'b1;
      end
    end
  end

  assign MISO         = active & (MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0]);
  assign MISO_oe      = active;
  assign tx_ready     = ~hold_full_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign underrun     = underrun_q;
  assign abort        = abort_q;
  assign frame_active = active;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: three instances (mode 0 / mode 3 / mode 1 16-bit LSB-first).
module tb_spi_slave_param;

  localparam int H = 5;  // SCK half period in clk cycles

  logic clk;
  logic rst_n;
  logic [2:0] sck, ssel, mosi, txv;
  logic [31:0] txd [3];
  wire  [2:0] miso, oe, txr, rxv, und, abt, fa;
  wire  [7:0]  rxd0, rxd1;
  wire  [15:0] rxd2;

  int cfg_cpol [3] = '{0, 1, 0};
  int cfg_cpha [3] = '{0, 1, 1};
  int cfg_msb  [3] = '{1, 1, 0};
  int cfg_w    [3] = '{8, 8, 16};

  int nvec = 0;
  int nerr = 0;
  int nrx [3];
  int nund [3];
  int nab [3];

  spi_slave_param #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst_n), .SSEL(ssel[0]), .SCK(sck[0]), .MOSI(mosi[0]),
    .MISO(miso[0]), .MISO_oe(oe[0]), .tx_data(txd[0][7:0]), .tx_valid(txv[0]),
    .tx_ready(txr[0]), .rx_data(rxd0), .rx_valid(rxv[0]), .underrun(und[0]),
    .abort(abt[0]), .frame_active(fa[0])
  );

  spi_slave_param #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst_n), .SSEL(ssel[1]), .SCK(sck[1]), .MOSI(mosi[1]),
    .MISO(miso[1]), .MISO_oe(oe[1]), .tx_data(txd[1][7:0]), .tx_valid(txv[1]),
    .tx_ready(txr[1]), .rx_data(rxd1), .rx_valid(rxv[1]), .underrun(und[1]),
    .abort(abt[1]), .frame_active(fa[1])
  );

  spi_slave_param #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst_n), .SSEL(ssel[2]), .SCK(sck[2]), .MOSI(mosi[2]),
    .MISO(miso[2]), .MISO_oe(oe[2]), .tx_data(txd[2][15:0]), .tx_valid(txv[2]),
    .tx_ready(txr[2]), .rx_data(rxd2), .rx_valid(rxv[2]), .underrun(und[2]),
    .abort(abt[2]), .frame_active(fa[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rxv[k]) nrx[k]++;
      if (und[k]) nund[k]++;
      if (abt[k]) nab[k]++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, nerr=%0d", nerr);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rx_of(input int sel);
    case (sel)
      0:       return {24'd0, rxd0};
      1:       return {24'd0, rxd1};
      default: return {16'd0, rxd2};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic write_tx(input int sel, input logic [31:0] data);
    for (int k = 0; k < 50 && !txr[sel]; k++) @(negedge clk);
    chk("tx_ready_before_write", {31'd0, txr[sel]}, 32'd1);
    txd[sel] = data;
    txv[sel] = 1'b1;
    @(negedge clk);
    txv[sel] = 1'b0;
  endtask

  task automatic ssel_low(input int sel);
    ssel[sel] = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic ssel_high(input int sel);
    repeat (H) @(negedge clk);
    ssel[sel] = 1'b1;
    repeat (H + 1) @(negedge clk);
  endtask

  // Clocks nbits bits of a word; coinc raises tx_valid in the exact cycle the slave loads bit 0.
  task automatic xfer(input int sel, input int nbits, input logic [31:0] word, input bit coinc,
                      input logic [31:0] wdata, output logic [31:0] got);
    logic cp;
    int   idx;
    got = '0;
    cp  = cfg_cpol[sel][0];
    for (int i = 0; i < nbits; i++) begin
      idx = (cfg_msb[sel] != 0) ? (cfg_w[sel] - 1 - i) : i;
      if (cfg_cpha[sel] == 0) begin
        mosi[sel] = word[idx];
        repeat (H) @(negedge clk);
        got[idx] = miso[sel];
        sck[sel] = ~cp;
        repeat (H) @(negedge clk);
        sck[sel] = cp;
      end else begin
        sck[sel]  = ~cp;
        mosi[sel] = word[idx];
        if (coinc && i == 0) begin
          repeat (2) @(negedge clk);
          txd[sel] = wdata;
          txv[sel] = 1'b1;
          @(negedge clk);
          txv[sel] = 1'b0;
          repeat (H - 3) @(negedge clk);
        end else begin
          repeat (H) @(negedge clk);
        end
        got[idx] = miso[sel];
        sck[sel] = cp;
        repeat (H) @(negedge clk);
      end
    end
  endtask

  typedef struct {
    int          sel;
    bit          pre;
    logic [31:0] tx;
    logic [31:0] mosi;
    logic [31:0] miso;
    int          und;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] got;
    int r0, u0, a0;

    vecs[0] = '{0, 1'b1, 32'hA5,   32'h3C,   32'hA5,   1};
    vecs[1] = '{0, 1'b0, 32'h00,   32'h00,   32'hFF,   2};
    vecs[2] = '{1, 1'b1, 32'h5A,   32'hC3,   32'h5A,   0};
    vecs[3] = '{1, 1'b0, 32'h00,   32'h7E,   32'hFF,   1};
    vecs[4] = '{2, 1'b1, 32'hBEEF, 32'h1234, 32'hBEEF, 0};
    vecs[5] = '{2, 1'b0, 32'h0000, 32'h8001, 32'hFFFF, 1};

    rst_n = 1'b0;
    ssel  = 3'b111;
    sck   = 3'b010;
    mosi  = '0;
    txv   = '0;
    for (int k = 0; k < 3; k++) txd[k] = '0;
    repeat (4) @(negedge clk);
    chk("rst_tx_ready", {31'd0, txr[0]}, 32'd1);
    chk("rst_miso_oe", {29'd0, miso[0], oe[0], fa[0]}, 32'd0);
    chk("rst_rx_data", rx_of(2), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      int s;
      s = vecs[i].sel;
      if (vecs[i].pre) begin
        write_tx(s, vecs[i].tx);
        chk($sformatf("v%0d_tx_ready_full", i), {31'd0, txr[s]}, 32'd0);
      end
      r0 = nrx[s]; u0 = nund[s]; a0 = nab[s];
      ssel_low(s);
      chk($sformatf("v%0d_active", i), {30'd0, oe[s], fa[s]}, 32'd3);
      xfer(s, cfg_w[s], vecs[i].mosi, 1'b0, 32'd0, got);
      ssel_high(s);
      chk($sformatf("v%0d_miso_word", i), got, vecs[i].miso);
      chk($sformatf("v%0d_rx_data", i), rx_of(s), vecs[i].mosi);
      chk($sformatf("v%0d_rx_valid_cnt", i), nrx[s] - r0, 32'd1);
      chk($sformatf("v%0d_underrun_cnt", i), nund[s] - u0, vecs[i].und);
      chk($sformatf("v%0d_abort_cnt", i), nab[s] - a0, 32'd0);
      chk($sformatf("v%0d_idle_outputs", i), {29'd0, miso[s], oe[s], fa[s]}, 32'd0);
      chk($sformatf("v%0d_tx_ready_empty", i), {31'd0, txr[s]}, 32'd1);
    end

    // Mode 3, two back-to-back words, only one word supplied.
    write_tx(1, 32'hC3);
    r0 = nrx[1]; u0 = nund[1];
    ssel_low(1);
    xfer(1, 8, 32'h01, 1'b0, 32'd0, got);
    chk("b2b_miso_w0", got, 32'hC3);
    chk("b2b_rx_w0", rx_of(1), 32'h01);
    xfer(1, 8, 32'h80, 1'b0, 32'd0, got);
    ssel_high(1);
    chk("b2b_miso_w1", got, 32'hFF);
    chk("b2b_rx_w1", rx_of(1), 32'h80);
    chk("b2b_underrun_cnt", nund[1] - u0, 32'd1);
    chk("b2b_rx_valid_cnt", nrx[1] - r0, 32'd2);

    // Write lands in the same cycle as a load from the empty holding register.
    r0 = nrx[1]; u0 = nund[1];
    ssel_low(1);
    xfer(1, 8, 32'h11, 1'b1, 32'hD2, got);
    chk("coinc_miso_w0", got, 32'hFF);
    chk("coinc_tx_ready_held", {31'd0, txr[1]}, 32'd0);
    xfer(1, 8, 32'h22, 1'b0, 32'd0, got);
    ssel_high(1);
    chk("coinc_miso_w1", got, 32'hD2);
    chk("coinc_underrun_cnt", nund[1] - u0, 32'd1);
    chk("coinc_rx_valid_cnt", nrx[1] - r0, 32'd2);
    chk("coinc_rx_data", rx_of(1), 32'h22);

    // SSEL released after 5 bits, then a clean frame.
    r0 = nrx[0]; a0 = nab[0];
    ssel_low(0);
    xfer(0, 5, 32'hF0, 1'b0, 32'd0, got);
    ssel_high(0);
    chk("abort_cnt", nab[0] - a0, 32'd1);
    chk("abort_no_rx_valid", nrx[0] - r0, 32'd0);
    chk("abort_idle", {31'd0, fa[0]}, 32'd0);
    r0 = nrx[0]; a0 = nab[0];
    ssel_low(0);
    xfer(0, 8, 32'h55, 1'b0, 32'd0, got);
    ssel_high(0);
    chk("post_abort_rx", rx_of(0), 32'h55);
    chk("post_abort_rx_valid_cnt", nrx[0] - r0, 32'd1);
    chk("post_abort_abort_cnt", nab[0] - a0, 32'd0);

    // Reset mid-word, released with SSEL still low.
    write_tx(0, 32'h3C);
    ssel_low(0);
    xfer(0, 3, 32'hFF, 1'b0, 32'd0, got);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_flags", {26'd0, miso[0], oe[0], fa[0], rxv[0], und[0], abt[0]}, 32'd0);
    chk("midrst_tx_ready", {31'd0, txr[0]}, 32'd1);
    chk("midrst_rx_data", rx_of(0), 32'd0);
    rst_n = 1'b1;
    r0 = nrx[0];
    repeat (4) @(negedge clk);
    xfer(0, 8, 32'hAA, 1'b0, 32'd0, got);
    repeat (H) @(negedge clk);
    chk("midrst_ignored_active", {30'd0, oe[0], fa[0]}, 32'd0);
    chk("midrst_ignored_miso", {31'd0, miso[0]}, 32'd0);
    chk("midrst_ignored_rx_valid", nrx[0] - r0, 32'd0);
    chk("midrst_ignored_rx_data", rx_of(0), 32'd0);
    ssel_high(0);
    ssel_low(0);
    xfer(0, 8, 32'h96, 1'b0, 32'd0, got);
    ssel_high(0);
    chk("midrst_next_rx", rx_of(0), 32'h96);
    chk("midrst_next_rx_valid_cnt", nrx[0] - r0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
